// File: rtl/bus_packetizer_if.sv
// Handshake bundle between the crypto engine, the packetizer and the bus interface block.
// master = packetizer side, slave = engine / bus-interface side.
interface bus_packetizer_if #(
  parameter int LEN_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_src;
  logic [1:0]       req_dest;
  logic [1:0]       req_op;
  logic [LEN_W-1:0] req_len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             send_valid;
  logic [7:0]       send_data;
  logic             send_ready;
  logic             ack;

  modport master (
    input  req_valid, req_src, req_dest, req_op, req_len, in_valid, in_data, send_ready,
    output req_ready, in_ready, send_valid, send_data, ack
  );

  modport slave (
    output req_valid, req_src, req_dest, req_op, req_len, in_valid, in_data, send_ready,
    input  req_ready, in_ready, send_valid, send_data, ack
  );
endinterface

// File: rtl/bus_packetizer.sv
// Frames a transfer request plus a prefetched payload FIFO into header+payload bus packets.
// Optional PKT_TIMEOUT_EN: abort a starved packet after TIMEOUT empty PAY cycles and raise sticky err.
module bus_packetizer #(
  parameter int DEPTH   = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  bus_packetizer_if.master bus,
  output logic            busy
`ifdef PKT_TIMEOUT_EN
  ,
  output logic            err
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

  function automatic logic [7:0] make_header(input logic [1:0] dest, input logic [1:0] src,
                                             input logic [1:0] op);
    return {2'b00, dest, src, op};
  endfunction

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count, count_after_pop, count_n;
  logic             push, pop, beat, abort;
  state_t           state, state_n;
  logic [7:0]       hdr, hdr_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [7:0]       head;
  logic             sv_n, ack_n;
  logic [7:0]       sd_n;

`ifdef PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
`endif

  always_comb begin
    beat            = bus.send_valid && bus.send_ready;
    push            = bus.in_valid && bus.in_ready;
    pop             = beat && (state == PAY);
    count_after_pop = count - CW'(pop);
    count_n         = count_after_pop + CW'(push);
    rd_ptr_n        = rd_ptr + PW'(pop);
    // A byte pushed into an otherwise empty FIFO becomes the head this very cycle
    head            = (count_after_pop == '0) ? bus.in_data : mem[rd_ptr_n];

    state_n = state;
    hdr_n   = hdr;
    rem_n   = rem;
    abort   = 1'b0;
    case (state)
      IDLE: if (bus.req_valid && bus.req_ready) begin
        state_n = HDR;
        hdr_n   = make_header(bus.req_dest, bus.req_src, bus.req_op);
        rem_n   = bus.req_len;
      end
      HDR:  if (beat) state_n = (rem == '0) ? GAP : PAY;
      PAY: begin
        if (beat) begin
          rem_n = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state_n = GAP;
        end
`ifdef PKT_TIMEOUT_EN
        else if (!bus.send_valid && to_cnt == TW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_n = GAP;
          rem_n   = '0;
        end
`endif
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state
    sv_n  = 1'b0;
    sd_n  = 8'h00;
    ack_n = 1'b0;
    case (state_n)
      HDR: begin
        sv_n  = 1'b1;
        sd_n  = hdr_n;
        ack_n = (rem_n == '0);
      end
      PAY: begin
        sv_n  = (count_n != '0);
        sd_n  = sv_n ? head : 8'h00;
        ack_n = sv_n && (rem_n == LEN_W'(1));
      end
      GAP:     ack_n = abort;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.req_ready  <= 1'b0;
      bus.in_ready   <= 1'b0;
      bus.send_valid <= 1'b0;
      bus.send_data  <= 8'h00;
      bus.ack        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      wr_ptr         <= wr_ptr + PW'(push);
      rd_ptr         <= rd_ptr_n;
      count          <= count_n;
      bus.req_ready  <= (state_n == IDLE);
      bus.in_ready   <= (count_n != CW'(DEPTH));
      bus.send_valid <= sv_n;
      bus.send_data  <= sd_n;
      bus.ack        <= ack_n;
      busy           <= (state_n != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
    hdr <= hdr_n;
    rem <= rem_n;
  end

`ifdef PKT_TIMEOUT_EN
  // Counts consecutive starved PAY cycles; err stays set until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      to_cnt <= (state == PAY && !bus.send_valid && !abort) ? to_cnt + TW'(1) : '0;
      if (abort) err <= 1'b1;
    end
  end
`endif
endmodule

// File: doc/bus_packetizer.md
Name: bus_packetizer

Overview:
- Upstream stage of the shared-bus interface. Turns one transfer request plus a payload byte stream from a crypto engine into a framed packet on the send_valid / send_data / send_ready / ack interface of the bus interface block.
- Each packet is one header byte (source/destination routing) followed by req_len payload bytes. ack marks the final byte.
- Contains a small payload FIFO, so the engine can stream ahead of bus arbitration.

Parameters:
- DEPTH, 8, payload FIFO depth in bytes; power of 2, at least 2.
- LEN_W, 4, width of req_len; maximum payload is 2^LEN_W-1 bytes.
- TIMEOUT, 255, starvation limit in cycles; used only with PKT_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  transfer request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_src  in  2  source module ID.
- req_dest  in  2  destination module ID.
- req_op  in  2  opcode, placed in header bits [1:0].
- req_len  in  LEN_W  payload byte count; 0 means header-only packet.
- in_valid  in  1  payload byte valid.
- in_data  in  8  payload byte.
- in_ready  out  1  FIFO can accept a byte.
- send_valid  out  1  byte presented to the bus interface.
- send_data  out  8  byte to send.
- send_ready  in  1  bus interface accepts the byte.
- ack  out  1  current send byte is the last byte of the packet.
- busy  out  1  packet in progress (state is not IDLE).
- err  out  1  sticky timeout flag; present only with PKT_TIMEOUT_EN.

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE and the FIFO is flushed.
  - Outputs: req_ready=0, in_ready=0, send_valid=0, send_data=0, ack=0, busy=0, err=0.
  - A reset mid-packet aborts the packet with no ack. Payload still in the FIFO is discarded.
- Beats:
  - A send beat completes on send_valid && send_ready. Only then may send_data or ack change.
  - A push completes on in_valid && in_ready.
- FIFO:
  - in_ready = !full, independent of any pop in the same cycle; a full FIFO with a simultaneous pop still blocks the push.
  - Push and pop in the same cycle when the FIFO is neither full nor empty leaves the count unchanged.
  - Pointers wrap modulo DEPTH. A count register of width log2(DEPTH)+1 distinguishes full from empty.
  - Pushes are allowed in any state, including IDLE (prefetch).
- Header byte: {2'b00, req_dest, req_src, req_op}.
  - Bits [3:2] carry the source and bits [5:4] the destination, matching what the bus interface decodes.
  - Bits [7:6] are always 0.
- FSM states: IDLE, HDR, PAY, GAP.
  - IDLE:
    - req_ready=1.
    - On request accept, latch src/dest/op into the header register and req_len into remaining; go to HDR.
  - HDR:
    - send_valid=1, send_data=header, ack=(remaining==0).
    - On beat: if remaining==0, go to GAP; otherwise go to PAY.
  - PAY:
    - send_valid=!fifo_empty, send_data=fifo head, ack=send_valid && (remaining==1).
    - On beat: pop the FIFO and decrement remaining. If remaining was 1, go to GAP.
    - With the FIFO empty: send_valid=0 and ack=0; stay in PAY.
  - GAP:
    - All send outputs low for exactly one cycle, giving the bus interface time to release ownership. Then go to IDLE.
    - req_ready=0 in GAP, so back-to-back packets have a 1-cycle bubble minimum.
- Latency: request accept to header valid is 1 cycle. With data prefetched and send_ready held high, a packet of N payload bytes occupies N+1 consecutive send cycles.
- send_ready low holds send_data and ack stable (no beat).
- Data overrun: bytes pushed beyond req_len stay in the FIFO and form the head of the next packet's payload. The engine is responsible for byte counts.

Optional Feature:
- Macro: PKT_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive PAY cycles with the FIFO empty; it clears on any pop or on leaving PAY.
  - When the count reaches TIMEOUT, the packet is aborted:
    - ack=1 with send_valid=0 for one cycle, so the bus interface releases the bus.
    - err is set, sticky until rst.
    - State goes to GAP and remaining is cleared.
- Not defined: no counter and no err port; PAY waits indefinitely for payload.

Test Plan:
- Header-only: req src=1, dest=2, op=3, len=0, send_ready=1 -> one beat with send_data=0x27 and ack=1; then 1 GAP cycle; req_ready returns 1 two cycles after the beat.
- Prefetched 3-byte packet: push 0xA1,0xA2,0xA3, then req src=0, dest=3, op=0, len=3 -> beats 0x30,0xA1,0xA2,0xA3 on consecutive cycles; ack=1 only on 0xA3.
- Backpressure: same packet with send_ready toggling 1,0,0,1,... -> send_data and ack held stable while send_ready=0; byte order unchanged; exactly 4 beats.
- FIFO full (DEPTH=8): push 9 bytes with no request -> in_ready=0 after the 8th push; then simultaneous pop and push attempt while full -> push blocked that cycle, count goes to 7.
- Starvation: len=2, push only 1 byte -> PAY with send_valid=0 after byte 1; with PKT_TIMEOUT_EN, after 255 empty cycles a 1-cycle ack pulse with send_valid=0 and err=1.
- Reset mid-PAY: rst asserted after the header beat -> next cycle busy=0, send_valid=0, ack=0, FIFO empty (in_ready=1 one cycle after rst deasserts).
